pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Consumer side of the hazard unit stall/flush/pc_en bundle. Owns the PC register and the
//  per-boundary valid+halt tokens for IF/ID, ID/EX, EX/MEM, MEM/WB. Applies stall/flush with a
//  fixed priority and drains the pipe on a decoded HALT. Sits between hazard unit and datapath latches.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
//  PC_STEP   4              sequential PC increment in bytes
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  nRST          in   1   synchronous active-low reset
//  pc_en         in   1   hazard unit: PC may update this cycle
//  stall_ifid/idex/xmem/wb  in 1 each  hold the named boundary register
//  flush_ifid/idex/xmem/wb  in 1 each  clear the named boundary register
//  take_branch   in   1   branch resolved taken (EX)
//  jump          in   1   jump resolved
//  branch_target in   32  target when take_branch
//  jump_target   in   32  target when jump
//  halt_id       in   1   instruction in IF/ID decodes as HALT
//  pc            out  32  current fetch PC
//  ifid_valid, idex_valid, xmem_valid, mwb_valid  out 1 each  boundary holds a live instruction
//  halt          out  1   sticky; HALT retired from MEM/WB (to hazard unit and caches)
//  pipe_state    out  2   pipe_state_t, for debug/bench
// BEHAVIOUR
//  Reset (nRST=0 at edge): pc=PC_INIT, all valid=0, all halt tokens=0, halt=0, state=RUN.
//  PC update (RUN only, pc_en=1): jump -> jump_target; else take_branch -> branch_target;
//   else pc+PC_STEP (mod 2^32, wraps silently). pc_en=0 or state!=RUN -> pc holds.
//  Boundary register k with upstream token u: flush_k -> {valid,halt}=0; else stall_k -> hold;
//   else load u. Flush beats stall when both asserted same cycle.
//  Upstream tokens: IF/ID loads valid=(state==RUN), halt=0; ID/EX loads {ifid_valid, halt_id&ifid_valid};
//   EX/MEM from ID/EX; MEM/WB from EX/MEM. Single-cycle latency per boundary.
//  FSM pipe_state_t: RUN -> DRAIN when an ID/EX load captures halt=1;
//   DRAIN -> HALTED when mwb_valid & mwb halt token =1; HALTED absorbing until reset.
//   DRAIN: PC frozen, IF/ID loads valid=0. Flush of the halt token in DRAIN (wrong-path HALT)
//   returns FSM to RUN the next cycle when no stage holds a halt token.
//  halt = (state==HALTED), registered; all valid outputs forced 0 in HALTED.
//  Simultaneous jump and take_branch: jump wins. Reset mid-DRAIN discards everything.
// CONFIGURATION
//  PIPELINE_PERF_CNT_EN defined: adds outputs stall_cycles[31:0], flush_cycles[31:0], retired[31:0];
//   counters reset to 0, increment when any stall_*, any flush_*, or mwb_valid (not halt) resp.;
//   saturate at 32'hFFFF_FFFF; freeze in HALTED.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  cpu_types_pkg: word_t, pipe_state_t {RUN, DRAIN, HALTED}, PC_STEP_C constant.
//  Sub-module pipe_token_reg: one boundary's {valid,halt} flop with flush>stall>load priority;
//   instantiated four times. FSM and PC mux live in pipeline_ctrl.
// TESTING
//  Reset then 3 cycles pc_en=1 -> pc 0,4,8,12; ifid..mwb valid ripple 1 per cycle.
//  stall_idex=1 and flush_idex=1 same cycle -> idex_valid=0 next cycle.
//  jump=1,take_branch=1, jump_target=0x40, branch_target=0x80 -> pc=0x40 next cycle.
//  pc=0xFFFF_FFFC, pc_en=1 -> pc=0x0000_0000.
//  halt_id with ifid_valid -> DRAIN, pc frozen; 3 cycles later HALTED, halt=1, valids 0.
//  halt token in ID/EX then flush_idex -> FSM back to RUN, pc resumes; nRST=0 in DRAIN -> pc=PC_INIT.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control slice: word type, pipe FSM states, PC step.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int unsigned PC_STEP_C = 4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit / datapath bundle seen by pipeline_ctrl.
// PIPELINE_PERF_CNT_EN adds the performance counter outputs.
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    logic        pc_en;
    logic        stall_ifid;
    logic        stall_idex;
    logic        stall_xmem;
    logic        stall_wb;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_xmem;
    logic        flush_wb;
    logic        take_branch;
    logic        jump;
    word_t       branch_target;
    word_t       jump_target;
    logic        halt_id;
    word_t       pc;
    logic        ifid_valid;
    logic        idex_valid;
    logic        xmem_valid;
    logic        mwb_valid;
    logic        halt;
    pipe_state_t pipe_state;
`ifdef PIPELINE_PERF_CNT_EN
    word_t       stall_cycles;
    word_t       flush_cycles;
    word_t       retired;
`endif

    modport master (
        output pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb,
        output flush_ifid, flush_idex, flush_xmem, flush_wb,
        output take_branch, jump, branch_target, jump_target, halt_id,
`ifdef PIPELINE_PERF_CNT_EN
        input  stall_cycles, flush_cycles, retired,
`endif
        input  pc, ifid_valid, idex_valid, xmem_valid, mwb_valid,
        input  halt, pipe_state
    );

    modport slave (
        input  pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb,
        input  flush_ifid, flush_idex, flush_xmem, flush_wb,
        input  take_branch, jump, branch_target, jump_target, halt_id,
`ifdef PIPELINE_PERF_CNT_EN
        output stall_cycles, flush_cycles, retired,
`endif
        output pc, ifid_valid, idex_valid, xmem_valid, mwb_valid,
        output halt, pipe_state
    );

endinterface

// File: rtl/pipeline_ctrl_token.sv
// One pipeline boundary's {valid, halt} token with flush > stall > load priority.
module pipe_token_reg (
    input  logic CLK,
    input  logic nRST,
    input  logic flush,
    input  logic stall,
    input  logic valid_i,
    input  logic halt_i,
    output logic valid_o,
    output logic halt_o
);

    logic valid_q, valid_d;
    logic halt_q, halt_d;

    always_comb begin
        valid_d = valid_q;
        halt_d  = halt_q;
        if (flush) begin
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (!stall) begin
            valid_d = valid_i;
            halt_d  = halt_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign valid_o = valid_q;
    assign halt_o  = halt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// PC register, boundary tokens and RUN/DRAIN/HALTED control for the pipe.
// PIPELINE_PERF_CNT_EN adds saturating stall/flush/retire counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT = 32'h0000_0000,
    parameter int unsigned PC_STEP = PC_STEP_C
) (
    input  logic           CLK,
    input  logic           nRST,
    pipeline_ctrl_if.slave bus
);

    pipe_state_t state_q, state_d;
    word_t       pc_q, pc_d;

    logic ifid_v, idex_v, xmem_v, mwb_v;
    logic ifid_h, idex_h, xmem_h, mwb_h;
    logic run, halted, fetch_v, idex_halt_ld;

    pipe_token_reg u_ifid (
        .CLK(CLK), .nRST(nRST),
        .flush(bus.flush_ifid), .stall(bus.stall_ifid),
        .valid_i(fetch_v), .halt_i(1'b0),
        .valid_o(ifid_v), .halt_o(ifid_h)
    );

    pipe_token_reg u_idex (
        .CLK(CLK), .nRST(nRST),
        .flush(bus.flush_idex), .stall(bus.stall_idex),
        .valid_i(ifid_v), .halt_i(bus.halt_id & ifid_v),
        .valid_o(idex_v), .halt_o(idex_h)
    );

    pipe_token_reg u_xmem (
        .CLK(CLK), .nRST(nRST),
        .flush(bus.flush_xmem), .stall(bus.stall_xmem),
        .valid_i(idex_v), .halt_i(idex_h),
        .valid_o(xmem_v), .halt_o(xmem_h)
    );

    pipe_token_reg u_mwb (
        .CLK(CLK), .nRST(nRST),
        .flush(bus.flush_wb), .stall(bus.stall_wb),
        .valid_i(xmem_v), .halt_i(xmem_h),
        .valid_o(mwb_v), .halt_o(mwb_h)
    );

    assign idex_halt_ld = !bus.flush_idex && !bus.stall_idex
                       && bus.halt_id && ifid_v;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A flushed (wrong-path) HALT leaves DRAIN once no boundary still carries it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (idex_halt_ld) state_d = DRAIN;
            end
            DRAIN: begin
                if (mwb_v && mwb_h) state_d = HALTED;
                else if (!(idex_h || xmem_h || mwb_h)) state_d = RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run     = (state_q == RUN);
        halted  = (state_q == HALTED);
        fetch_v = run;
    end

    // Jump outranks a simultaneously resolved branch.
    always_comb begin
        pc_d = pc_q;
        if (run && bus.pc_en) begin
            if (bus.jump) pc_d = bus.jump_target;
            else if (bus.take_branch) pc_d = bus.branch_target;
            else pc_d = pc_q + word_t'(PC_STEP);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ifid_valid = ifid_v & ~halted;
    assign bus.idex_valid = idex_v & ~halted;
    assign bus.xmem_valid = xmem_v & ~halted;
    assign bus.mwb_valid  = mwb_v & ~halted;
    assign bus.halt       = halted;
    assign bus.pipe_state = state_q;

`ifdef PIPELINE_PERF_CNT_EN
    word_t stall_cnt_q, stall_cnt_d;
    word_t flush_cnt_q, flush_cnt_d;
    word_t ret_cnt_q, ret_cnt_d;
    logic  any_stall, any_flush, retire;

    always_comb begin
        any_stall = bus.stall_ifid | bus.stall_idex
                  | bus.stall_xmem | bus.stall_wb;
        any_flush = bus.flush_ifid | bus.flush_idex
                  | bus.flush_xmem | bus.flush_wb;
        retire    = mwb_v & ~mwb_h;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (!halted) begin
            if (any_stall && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (any_flush && flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + 32'd1;
            if (retire && ret_cnt_q != '1)
                ret_cnt_d = ret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_cycles = flush_cnt_q;
    assign bus.retired      = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: PC sequencing, token ripple, halt drain.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   n_chk;
    int   n_err;

    pipeline_ctrl_if bif ();

    pipeline_ctrl #(
        .PC_INIT(32'h0000_0000),
        .PC_STEP(4)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bif.pc_en         = 1'b0;
        bif.stall_ifid    = 1'b0;
        bif.stall_idex    = 1'b0;
        bif.stall_xmem    = 1'b0;
        bif.stall_wb      = 1'b0;
        bif.flush_ifid    = 1'b0;
        bif.flush_idex    = 1'b0;
        bif.flush_xmem    = 1'b0;
        bif.flush_wb      = 1'b0;
        bif.take_branch   = 1'b0;
        bif.jump          = 1'b0;
        bif.branch_target = '0;
        bif.jump_target   = '0;
        bif.halt_id       = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle();
        nRST = 1'b0;
        tick();
        tick();
        check("rst_pc", bif.pc, 32'h0);
        check("rst_ifid", 32'(bif.ifid_valid), 32'd0);
        check("rst_mwb", 32'(bif.mwb_valid), 32'd0);
        check("rst_halt", 32'(bif.halt), 32'd0);
        check("rst_state", 32'(bif.pipe_state), 32'd0);

        nRST = 1'b1;
        bif.pc_en = 1'b1;
        tick();
        check("e1_pc", bif.pc, 32'd4);
        check("e1_ifid", 32'(bif.ifid_valid), 32'd1);
        check("e1_idex", 32'(bif.idex_valid), 32'd0);
        tick();
        check("e2_pc", bif.pc, 32'd8);
        check("e2_idex", 32'(bif.idex_valid), 32'd1);
        check("e2_xmem", 32'(bif.xmem_valid), 32'd0);
        tick();
        check("e3_pc", bif.pc, 32'd12);
        check("e3_xmem", 32'(bif.xmem_valid), 32'd1);
        check("e3_mwb", 32'(bif.mwb_valid), 32'd0);
        tick();
        check("e4_pc", bif.pc, 32'd16);
        check("e4_mwb", 32'(bif.mwb_valid), 32'd1);

        bif.stall_idex = 1'b1;
        bif.flush_idex = 1'b1;
        tick();
        check("flush_over_stall", 32'(bif.idex_valid), 32'd0);
        check("e5_xmem", 32'(bif.xmem_valid), 32'd1);
        check("e5_pc", bif.pc, 32'd20);
        bif.stall_idex = 1'b0;
        bif.flush_idex = 1'b0;
        tick();
        check("e6_idex", 32'(bif.idex_valid), 32'd1);
        check("e6_xmem", 32'(bif.xmem_valid), 32'd0);

        bif.stall_wb = 1'b1;
        bif.pc_en    = 1'b0;
        tick();
        check("stall_wb_hold", 32'(bif.mwb_valid), 32'd1);
        check("pc_en0_hold", bif.pc, 32'd24);
        bif.stall_wb = 1'b0;
        bif.pc_en    = 1'b1;

        bif.jump          = 1'b1;
        bif.take_branch   = 1'b1;
        bif.jump_target   = 32'h40;
        bif.branch_target = 32'h80;
        tick();
        check("jump_wins", bif.pc, 32'h40);
        bif.jump = 1'b0;
        tick();
        check("branch", bif.pc, 32'h80);
        bif.take_branch = 1'b0;
        bif.jump        = 1'b1;
        bif.jump_target = 32'hFFFF_FFFC;
        tick();
        check("pc_top", bif.pc, 32'hFFFF_FFFC);
        bif.jump = 1'b0;
        tick();
        check("pc_wrap", bif.pc, 32'h0);

        bif.halt_id = 1'b1;
        tick();
        bif.halt_id = 1'b0;
        check("drain_enter", 32'(bif.pipe_state), 32'd1);
        check("drain_pc", bif.pc, 32'd4);
        tick();
        check("drain_frozen", bif.pc, 32'd4);
        check("drain_ifid0", 32'(bif.ifid_valid), 32'd0);
        tick();
        check("drain_e2_halt", 32'(bif.halt), 32'd0);
        tick();
        check("halted_state", 32'(bif.pipe_state), 32'd2);
        check("halted_halt", 32'(bif.halt), 32'd1);
        check("halted_mwb", 32'(bif.mwb_valid), 32'd0);
        check("halted_idex", 32'(bif.idex_valid), 32'd0);
        check("halted_pc", bif.pc, 32'd4);
        tick();
        check("halted_sticky", 32'(bif.halt), 32'd1);

        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check("rst2_pc", bif.pc, 32'h0);
        check("rst2_state", 32'(bif.pipe_state), 32'd0);
        tick();
        check("wp_e1_pc", bif.pc, 32'd4);
        bif.halt_id = 1'b1;
        tick();
        bif.halt_id = 1'b0;
        check("wp_drain", 32'(bif.pipe_state), 32'd1);
        check("wp_pc", bif.pc, 32'd8);
        bif.flush_idex = 1'b1;
        bif.flush_xmem = 1'b1;
        tick();
        bif.flush_idex = 1'b0;
        bif.flush_xmem = 1'b0;
        check("wp_idex0", 32'(bif.idex_valid), 32'd0);
        check("wp_pc_hold", bif.pc, 32'd8);
        tick();
        check("wp_run", 32'(bif.pipe_state), 32'd0);
        check("wp_pc_hold2", bif.pc, 32'd8);
        tick();
        check("wp_resume", bif.pc, 32'd12);
        check("wp_ifid", 32'(bif.ifid_valid), 32'd1);

        bif.halt_id = 1'b1;
        tick();
        bif.halt_id = 1'b0;
        check("rd_drain", 32'(bif.pipe_state), 32'd1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check("rd_pc", bif.pc, 32'h0);
        check("rd_state", 32'(bif.pipe_state), 32'd0);
        check("rd_idex", 32'(bif.idex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
